// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: step encodings,
// instruction opcodes, ALU operation codes and the control strobe bundle.
package cpu_pkg;

    // Step encodings, chosen so they can be read directly off the debug port.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0000,
        ST_T0   = 4'b0111,
        ST_T1   = 4'b1000,
        ST_T2   = 4'b1001,
        ST_T3   = 4'b1010,
        ST_T4   = 4'b1011,
        ST_T5   = 4'b1100,
        ST_T6   = 4'b1101,
        ST_T7   = 4'b1110,
        ST_HALT = 4'b1111
    } state_e;

    // Instruction opcodes (IR[31:27]).
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation codes driven on the opcode output.
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // Every datapath strobe the sequencer can drive, plus the ALU operation.
    typedef struct packed {
        logic       pcout;
        logic       zhighout;
        logic       zlowout;
        logic       mdrout;
        logic       cout;
        logic       rout;
        logic       baout;
        logic       marin;
        logic       pcin;
        logic       mdrin;
        logic       irin;
        logic       yin;
        logic       zlowin;
        logic       zhighin;
        logic       hiin;
        logic       loin;
        logic       rin;
        logic       conin;
        logic       outportin;
        logic       incpc;
        logic       read;
        logic       write;
        logic       gra;
        logic       grb;
        logic       grc;
        logic [4:0] opcode;
    } ctrl_t;

    // Memory-reference instructions share the base+offset address steps.
    function automatic logic is_mem_ref(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic is_reg_alu(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SHL);
    endfunction

    function automatic logic is_imm_alu(input logic [4:0] op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    // ALU operation used by the immediate forms.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational step decoder: maps the current step and instruction opcode to
// the strobe bundle, the step to take next, and whether the step waits on memory.
module control_decode
    import cpu_pkg::*;
(
    input  state_e     state_i,
    input  logic [4:0] op_i,
    output ctrl_t      ctrl_o,
    output state_e     next_o,
    output logic       mem_step_o,
    output logic       bad_o
);

    // Strobes and successor step for each (step, opcode) pair.
    always_comb begin
        ctrl_o     = '0;
        next_o     = state_i;
        mem_step_o = 1'b0;
        bad_o      = 1'b0;
        case (state_i)
            ST_T0: begin
                ctrl_o.pcout  = 1'b1;
                ctrl_o.marin  = 1'b1;
                ctrl_o.incpc  = 1'b1;
                ctrl_o.zlowin = 1'b1;
                next_o        = ST_T1;
            end
            ST_T1: begin
                ctrl_o.zlowout = 1'b1;
                ctrl_o.pcin    = 1'b1;
                ctrl_o.read    = 1'b1;
                ctrl_o.mdrin   = 1'b1;
                mem_step_o     = 1'b1;
                next_o         = ST_T2;
            end
            ST_T2: begin
                ctrl_o.mdrout = 1'b1;
                ctrl_o.irin   = 1'b1;
                if (op_i == OP_NOP) begin
                    next_o = ST_T0;
                end else if (op_i == OP_HALT) begin
                    next_o = ST_HALT;
                end else if (is_mem_ref(op_i) || is_reg_alu(op_i) || is_imm_alu(op_i)) begin
                    next_o = ST_T3;
                end else begin
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_T3: begin
                ctrl_o.grb = 1'b1;
                ctrl_o.yin = 1'b1;
                next_o     = ST_T4;
                if (is_mem_ref(op_i)) begin
                    ctrl_o.baout = 1'b1;
                end else if (is_reg_alu(op_i) || is_imm_alu(op_i)) begin
                    ctrl_o.rout = 1'b1;
                end else begin
                    ctrl_o = '0;
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_T4: begin
                ctrl_o.zlowin = 1'b1;
                next_o        = ST_T5;
                if (is_reg_alu(op_i)) begin
                    ctrl_o.grc    = 1'b1;
                    ctrl_o.rout   = 1'b1;
                    ctrl_o.opcode = op_i;
                end else if (is_mem_ref(op_i) || is_imm_alu(op_i)) begin
                    ctrl_o.cout   = 1'b1;
                    ctrl_o.opcode = is_imm_alu(op_i) ? imm_alu_op(op_i) : ALU_ADD;
                end else begin
                    ctrl_o = '0;
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_T5: begin
                ctrl_o.zlowout = 1'b1;
                if (op_i == OP_LD || op_i == OP_ST) begin
                    ctrl_o.marin = 1'b1;
                    next_o       = ST_T6;
                end else if (op_i == OP_LDI || is_reg_alu(op_i) || is_imm_alu(op_i)) begin
                    ctrl_o.gra = 1'b1;
                    ctrl_o.rin = 1'b1;
                    next_o     = ST_T0;
                end else begin
                    ctrl_o = '0;
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_T6: begin
                next_o = ST_T7;
                if (op_i == OP_LD) begin
                    ctrl_o.read  = 1'b1;
                    ctrl_o.mdrin = 1'b1;
                    mem_step_o   = 1'b1;
                end else if (op_i == OP_ST) begin
                    ctrl_o.gra   = 1'b1;
                    ctrl_o.rout  = 1'b1;
                    ctrl_o.mdrin = 1'b1;
                end else begin
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_T7: begin
                next_o = ST_T0;
                if (op_i == OP_LD) begin
                    ctrl_o.mdrout = 1'b1;
                    ctrl_o.gra    = 1'b1;
                    ctrl_o.rin    = 1'b1;
                end else if (op_i == OP_ST) begin
                    ctrl_o.write = 1'b1;
                    mem_step_o   = 1'b1;
                end else begin
                    next_o = ST_HALT;
                    bad_o  = 1'b1;
                end
            end
            ST_HALT: next_o = ST_HALT;
            default: next_o = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: owns the step register, the
// memory-wait timeout counter and the sticky fault flag; strobes are decoded
// combinationally from the registered step and the instruction register.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        Rout,
    output logic        BAout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        HIout,
    output logic        LOout,
    output logic        Yout,
    output logic        InPortout,
    output logic [4:0]  opcode,
    output logic [3:0]  step,
    output logic        halted,
    output logic        fault
);

    state_e         state_q, state_d;
    logic [TW-1:0]  cnt_q, cnt_d;
    logic           fault_q, fault_d;

    ctrl_t          ctrl;
    state_e         dec_next;
    logic           dec_mem;
    logic           dec_bad;

    // Only the opcode field steers the sequencer; register fields go to DataPath.
    logic           unused_ir;
    assign unused_ir = ^IR[26:0];

    control_decode u_decode (
        .state_i    (state_q),
        .op_i       (IR[31:27]),
        .ctrl_o     (ctrl),
        .next_o     (dec_next),
        .mem_step_o (dec_mem),
        .bad_o      (dec_bad)
    );

    // Next step: wait for start in IDLE, stall memory steps until ready or timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        fault_d = fault_q;
        if (state_q == ST_IDLE) begin
            if (start) state_d = ST_T0;
        end else if (dec_mem && !mem_ready) begin
            if (cnt_q == TW'(MEM_TIMEOUT - 1)) begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            state_d = dec_next;
            if (dec_bad) fault_d = 1'b1;
        end
    end

    // Step register, stall counter and sticky fault; clear aborts immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign PCout     = ctrl.pcout;
    assign Zhighout  = ctrl.zhighout;
    assign Zlowout   = ctrl.zlowout;
    assign MDRout    = ctrl.mdrout;
    assign Cout      = ctrl.cout;
    assign Rout      = ctrl.rout;
    assign BAout     = ctrl.baout;
    assign MARin     = ctrl.marin;
    assign PCin      = ctrl.pcin;
    assign MDRin     = ctrl.mdrin;
    assign IRin      = ctrl.irin;
    assign Yin       = ctrl.yin;
    assign ZLowIn    = ctrl.zlowin;
    assign ZHighIn   = ctrl.zhighin;
    assign HIin      = ctrl.hiin;
    assign LOin      = ctrl.loin;
    assign Rin       = ctrl.rin;
    assign CONin     = ctrl.conin;
    assign OutPortin = ctrl.outportin;
    assign IncPC     = ctrl.incpc;
    assign Read      = ctrl.read;
    assign Write     = ctrl.write;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign opcode    = ctrl.opcode;
    assign HIout     = 1'b0;
    assign LOout     = 1'b0;
    assign Yout      = 1'b0;
    assign InPortout = 1'b0;
    assign step      = state_q;
    assign halted    = (state_q == ST_HALT);
    assign fault     = fault_q;

endmodule
